// File: rtl/imu_spi_pkg.sv
// Shared types and command tables for the IMU SPI sequencer.
// Command words are 16-bit frames: bit 15 set marks a register read.
package imu_spi_pkg;

   typedef enum logic [2:0] {
      StPorWait,
      StWrSnd,
      StWrWait,
      StIdle,
      StRdSnd,
      StRdWait
   } imu_state_e;

   localparam logic [15:0] WrTable [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
   localparam logic [15:0] RdTable [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

   localparam logic [1:0] SlotPtchLo = 2'd0;
   localparam logic [1:0] SlotPtchHi = 2'd1;
   localparam logic [1:0] SlotAzLo   = 2'd2;
   localparam logic [1:0] SlotAzHi   = 2'd3;
   localparam logic [1:0] IdxLast    = 2'd3;

endpackage

// File: rtl/imu_spi_seq.sv
// Sequences the SPI transceiver: power-on wait, sensor configuration burst,
// then four register reads per data-ready interrupt to build pitch rate and Z accel.
module imu_spi_seq
   import imu_spi_pkg::*;
#(
   parameter int unsigned POR_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        INT,
   input  logic        done,
   input  logic [15:0] resp,
   output logic        snd,
   output logic [15:0] cmd,
   output logic [15:0] ptch_rt,
   output logic [15:0] az,
   output logic        vld,
   output logic        init_done
);

   imu_state_e       state_q, state_d;
   logic [POR_W-1:0] por_cnt_q, por_cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      cmd_q, cmd_d;
   logic             init_done_q, init_done_d;
   logic [2:0]       int_sync_q;
   logic             int_pend_q;
   logic             done_q;
   logic [7:0]       byte_q [4];
   logic             ld_q;
   logic             vld_q;
   logic [15:0]      ptch_q, az_q;
   logic             done_rise, int_rise, leave_idle, cap;
   logic             unused_resp;

   assign unused_resp = ^resp[15:8];

   // A done left high from the previous frame must not count; only a fresh edge does.
   assign done_rise = done & ~done_q;
   assign int_rise  = int_sync_q[1] & ~int_sync_q[2];

   always_comb begin
      state_d     = state_q;
      por_cnt_d   = por_cnt_q;
      idx_d       = idx_q;
      cmd_d       = cmd_q;
      init_done_d = init_done_q;
      snd         = 1'b0;
      cap         = 1'b0;
      leave_idle  = 1'b0;
      unique case (state_q)
         StPorWait: begin
            por_cnt_d = por_cnt_q + POR_W'(1);
            if (&por_cnt_q) begin
               idx_d   = '0;
               state_d = StWrSnd;
            end
         end
         StWrSnd: begin
            snd     = 1'b1;
            state_d = StWrWait;
         end
         StWrWait: begin
            if (done_rise) begin
               if (idx_q == IdxLast) begin
                  init_done_d = 1'b1;
                  state_d     = StIdle;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = StWrSnd;
               end
            end
         end
         StIdle: begin
            if (int_pend_q && init_done_q) begin
               idx_d      = '0;
               leave_idle = 1'b1;
               state_d    = StRdSnd;
            end
         end
         StRdSnd: begin
            snd     = 1'b1;
            state_d = StRdWait;
         end
         StRdWait: begin
            if (done_rise) begin
               cap = 1'b1;
               if (idx_q == IdxLast) begin
                  state_d = StIdle;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = StRdSnd;
               end
            end
         end
         default: state_d = StPorWait;
      endcase
      // Load cmd on entry so it is already stable during the snd cycle.
      if (state_d == StWrSnd) begin
         cmd_d = WrTable[idx_d];
      end else if (state_d == StRdSnd) begin
         cmd_d = RdTable[idx_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StPorWait;
         por_cnt_q   <= '0;
         idx_q       <= '0;
         cmd_q       <= '0;
         init_done_q <= 1'b0;
         int_sync_q  <= '0;
         int_pend_q  <= 1'b0;
         done_q      <= 1'b0;
         byte_q      <= '{default: '0};
         ld_q        <= 1'b0;
         vld_q       <= 1'b0;
         ptch_q      <= '0;
         az_q        <= '0;
      end else begin
         state_q     <= state_d;
         por_cnt_q   <= por_cnt_d;
         idx_q       <= idx_d;
         cmd_q       <= cmd_d;
         init_done_q <= init_done_d;
         int_sync_q  <= {int_sync_q[1:0], INT};
         done_q      <= done;
         // A new edge wins over the clear so an interrupt is never lost.
         if (int_rise) begin
            int_pend_q <= 1'b1;
         end else if (leave_idle) begin
            int_pend_q <= 1'b0;
         end
         if (cap) begin
            byte_q[idx_q] <= resp[7:0];
         end
         ld_q  <= cap && (idx_q == IdxLast);
         vld_q <= ld_q;
         if (ld_q) begin
            ptch_q <= {byte_q[SlotPtchHi], byte_q[SlotPtchLo]};
            az_q   <= {byte_q[SlotAzHi], byte_q[SlotAzLo]};
         end
      end
   end

   assign cmd       = cmd_q;
   assign ptch_rt   = ptch_q;
   assign az        = az_q;
   assign vld       = vld_q;
   assign init_done = init_done_q;

endmodule

// File: doc/imu_spi_seq.md
Name: imu_spi_seq

Overview:
- Controller that sequences the SPI monarch transceiver, which has a 16-bit command/response frame and a 1/32 SCLK.
- After power-on it configures the inertial sensor with a fixed burst of register writes.
- It then services each sensor data-ready interrupt with four register reads and assembles 16-bit pitch-rate and Z-acceleration words for the downstream integrator.
- It sits between the inertial integrator and the SPI transceiver. It owns the transceiver's snd/cmd inputs and consumes its done/resp outputs.

Parameters:
- POR_W, 16: width of the power-on wait counter. The wait ends when the counter is all ones (2^POR_W - 1 cycles). Benches may use 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- INT  in  1  sensor data-ready interrupt; asynchronous, active high
- done  in  1  transceiver done; sticky level, cleared by the transceiver one cycle after snd
- resp  in  16  transceiver response; only resp[7:0] is used
- snd  out  1  one-cycle pulse that starts a frame
- cmd  out  16  frame to send; must be stable in the cycle snd=1
- ptch_rt  out  16  signed pitch rate, {high byte, low byte}
- az  out  16  signed Z acceleration, {high byte, low byte}
- vld  out  1  one-cycle pulse: ptch_rt and az have just updated together
- init_done  out  1  level: configuration writes are complete

Behaviour:
- Reset values: snd=0, cmd=0, ptch_rt=0, az=0, vld=0, init_done=0, state=POR_WAIT, all counters 0.
- INT handling:
  - INT is double-flopped for metastability, then a third flop provides rising-edge detection.
  - A rising edge sets int_pend.
  - int_pend clears in the cycle the read sequence leaves IDLE.
  - An edge arriving during a read sequence sets int_pend again, so at most one sample is queued.
- done handling: frame completion = rising edge of done (done & ~done_q). A stale high done from the previous frame must never count as completion.
- Write table (index 0..3): 0x0D02, 0x1053, 0x1150, 0x1460.
- Read table (index 0..3): 0xA200 (pitch low), 0xA300 (pitch high), 0xAC00 (az low), 0xAD00 (az high).
- States:
  - POR_WAIT: counter increments every cycle. When all ones, set idx=0 and go to WR_SND.
  - WR_SND: snd=1, cmd=write_table[idx]; go to WR_WAIT.
  - WR_WAIT: on done rising edge:
    - if idx==3, set init_done=1 and go to IDLE;
    - otherwise idx++ and go to WR_SND.
  - IDLE: if int_pend and init_done, set idx=0 and go to RD_SND.
  - RD_SND: snd=1, cmd=read_table[idx]; go to RD_WAIT.
  - RD_WAIT: on done rising edge, capture resp[7:0] into byte register idx. Then:
    - if idx==3, go to IDLE;
    - otherwise idx++ and go to RD_SND.
- Output update:
  - ptch_rt and az load together, one cycle after the fourth byte is captured.
  - vld pulses high in that same cycle.
  - Outputs otherwise hold their value.
- cmd holds its last value outside the SND states. snd is never high in two consecutive cycles.
- Latency:
  - From an INT edge to vld: 3 cycles of synchronization plus four frames plus one cycle.
  - Each frame takes about 550 clk cycles with the current transceiver. The bench must not depend on the exact frame count; it keys on done.
- INT edges seen during POR_WAIT or the write phase stay pending and are serviced on reaching IDLE.
- Reset mid-frame returns to POR_WAIT and re-runs the full configuration. No partial outputs are retained.
- idx is 2 bits and never wraps in service; idx==3 is the terminal test in both WAIT states.

Decomposition:
- Package imu_spi_pkg holds:
  - the state enum (POR_WAIT, WR_SND, WR_WAIT, IDLE, RD_SND, RD_WAIT);
  - localparam arrays for the write and read command tables;
  - the byte-slot index constants.
- No sub-module is needed inside; the block is one FSM plus a datapath.
- The top level instantiates this block alongside the existing SPI monarch transceiver.

Test Plan:
- POR and configuration: POR_W=4, rst_n released, transceiver model asserts done 40 cycles after each snd → snd stays 0 for 15 cycles; then cmd sequence 0x0D02, 0x1053, 0x1150, 0x1460; init_done=1 after the fourth done edge; exactly 4 snd pulses.
- Single sample: after init, pulse INT; resp[7:0] returns 0x34, 0x12, 0xCD, 0xAB → cmd sequence 0xA200, 0xA300, 0xAC00, 0xAD00; ptch_rt=0x1234; az=0xABCD; vld high for exactly 1 cycle.
- Stale done: model holds done=1 continuously until cleared after snd → controller waits for a fresh rising edge; no frame is skipped; still exactly 4 snd pulses per sample.
- INT during a read sequence: second INT edge arrives during frame 2 → exactly 8 reads total and 2 vld pulses; a third edge in the same window still yields only 2 vld pulses.
- INT before init_done: INT edge arrives during POR_WAIT → reads begin only after the fourth write completes; 1 vld pulse.
- Reset mid-read: rst_n low during frame 3 → all outputs return to 0 and state is POR_WAIT; the write burst repeats; ptch_rt and az stay 0 until a new INT.
